// File: rtl/uart_bridge_pkg.sv
// Shared state encoding and default protocol constants for the UART-to-memory bridge.
package uart_bridge_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_ADDR  = 4'd1,
    GET_LEN   = 4'd2,
    GET_WDATA = 4'd3,
    RD_ISSUE  = 4'd4,
    RD_WAIT   = 4'd5,
    RD_SEND   = 4'd6,
    SEND_RSP  = 4'd7
  } state_t;

  localparam logic [7:0] CMD_RD_DEF   = 8'h01;
  localparam logic [7:0] CMD_WR_DEF   = 8'h02;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Inter-byte idle counter; expired is high during the TIMEOUT_CYC-th consecutive enabled idle cycle.
module bridge_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Decodes framed read/write packets from the UART RX stream and drives a synchronous memory port.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  CMD_RD      = CMD_RD_DEF,
  parameter logic [7:0]  CMD_WR      = CMD_WR_DEF,
  parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_data_rx,
  input  logic [7:0]              data_rx,
  input  logic                    busy,
  input  logic                    block,
  output logic                    new_data_tx,
  output logic [7:0]              data_tx,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic                    mem_wr_en,
  output logic [7:0]              mem_wr_data,
  input  logic [7:0]              mem_rd_data,
  output logic [7:0]              debug
);

  localparam int unsigned ADDR_W = 8 * ADDR_BYTES;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        count;
  logic [7:0]        cmd;
  logic [1:0]        byte_cnt;
  logic [1:0]        lat_cnt;
  logic              tx_gap;
  logic              sticky_timeout, sticky_badcmd;
  logic              tx_fire, expired, to_clr, to_en;
  logic              known_cmd;

  assign known_cmd = (data_rx == CMD_RD) || (data_rx == CMD_WR);
  // rst gates the strobes so a reset arriving mid-burst can never emit a byte or a write
  assign tx_fire   = ((state == RD_SEND) || (state == SEND_RSP)) && !busy && !block && !tx_gap && !rst;
  assign to_clr    = new_data_rx || (state == IDLE);
  assign to_en     = (state == GET_ADDR) || (state == GET_LEN) || (state == GET_WDATA);
  assign mem_addr  = addr;

  bridge_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (to_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (new_data_rx) state_nx = known_cmd ? GET_ADDR : SEND_RSP;
      GET_ADDR:  if (new_data_rx) begin
                   if (byte_cnt == 2'(ADDR_BYTES - 1)) state_nx = GET_LEN;
                 end else if (expired) state_nx = IDLE;
      GET_LEN:   if (new_data_rx) state_nx = (cmd == CMD_RD) ? RD_ISSUE : GET_WDATA;
                 else if (expired) state_nx = IDLE;
      GET_WDATA: if (new_data_rx) begin
                   if (count == 9'd1) state_nx = SEND_RSP;
                 end else if (expired) state_nx = IDLE;
      RD_ISSUE:  state_nx = (RD_LAT == 0) ? RD_SEND : RD_WAIT;
      RD_WAIT:   if (lat_cnt == 2'(RD_LAT)) state_nx = RD_SEND;
      RD_SEND:   if (tx_fire) state_nx = (count == 9'd1) ? IDLE : RD_ISSUE;
      SEND_RSP:  if (tx_fire) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    new_data_tx = tx_fire;
    mem_wr_en   = (state == GET_WDATA) && new_data_rx && !rst;
    mem_wr_data = mem_wr_en ? data_rx : '0;
    debug       = {state, sticky_timeout, sticky_badcmd, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr           <= '0;
      count          <= '0;
      cmd            <= '0;
      byte_cnt       <= '0;
      lat_cnt        <= '0;
      data_tx        <= '0;
      tx_gap         <= 1'b0;
      sticky_timeout <= 1'b0;
      sticky_badcmd  <= 1'b0;
    end else begin
      tx_gap <= tx_fire;
      if (expired && !new_data_rx) sticky_timeout <= 1'b1;
      unique case (state)
        IDLE: if (new_data_rx) begin
          cmd      <= data_rx;
          byte_cnt <= '0;
          if (!known_cmd) begin
            sticky_badcmd <= 1'b1;
            data_tx       <= NAK_BYTE;
          end
        end
        GET_ADDR: if (new_data_rx) begin
          addr     <= (addr << 8) | ADDR_W'(data_rx);
          byte_cnt <= byte_cnt + 2'd1;
        end
        GET_LEN: if (new_data_rx) count <= {1'b0, data_rx} + 9'd1;
        GET_WDATA: if (new_data_rx) begin
          addr  <= addr + ADDR_W'(1);
          count <= count - 9'd1;
          if (count == 9'd1) data_tx <= ACK_BYTE;
        end
        RD_ISSUE: begin
          lat_cnt <= 2'd1;
          if (RD_LAT == 0) data_tx <= mem_rd_data;
        end
        RD_WAIT: begin
          if (lat_cnt == 2'(RD_LAT)) data_tx <= mem_rd_data;
          else                       lat_cnt <= lat_cnt + 2'd1;
        end
        RD_SEND: if (tx_fire) begin
          addr  <= addr + ADDR_W'(1);
          count <= count - 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
